// File: rtl/uart_tx_8n1.sv
// 8N1 (optionally 8E1) asynchronous serial transmitter with a valid/ready byte input.
// All outputs are registered; tx idles high and tx_oe arms on the first clock after reset.
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA   | eight data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even-parity bit (only when PARITY_EN=1)
// STOP   | stop bit (tx=1); frame_done pulses as it completes
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [7:0]        shift_reg;
    logic              parity_bit;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            baud_cnt   <= '0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_oe      <= 1'b0;
        end else begin
            tx_oe      <= 1'b1;
            frame_done <= 1'b0;

            // One shared bit timer for every non-idle state.
            if (state != IDLE) begin
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shift_reg  <= tx_data;
                        parity_bit <= ^tx_data;
                        baud_cnt   <= '0;
                        bit_cnt    <= 3'd0;
                        tx         <= 1'b0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // tx already shows bit 0 of the register; present the next one
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        tx         <= 1'b1;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: one instance without parity, one with even parity, both at 4 clocks/bit.
// Expected line waveforms come from the frame format (start, data LSB first, parity, stop).
`timescale 1ns/1ps
module tb_uart_tx_8n1;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       sel;
    int         n_cmp;
    int         n_bad;

    logic tx_valid_0, tx_ready_0, tx_0, tx_oe_0, busy_0, frame_done_0;
    logic tx_valid_1, tx_ready_1, tx_1, tx_oe_1, busy_1, frame_done_1;
    logic tx_m, tx_ready_m, busy_m, done_m;

    assign tx_valid_0 = drv_valid & ~sel;
    assign tx_valid_1 = drv_valid & sel;
    assign tx_m       = sel ? tx_1 : tx_0;
    assign tx_ready_m = sel ? tx_ready_1 : tx_ready_0;
    assign busy_m     = sel ? busy_1 : busy_0;
    assign done_m     = sel ? frame_done_1 : frame_done_0;

    uart_tx_8n1 #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut_0 (
        .clk(clk), .rst(rst), .tx_data(drv_data), .tx_valid(tx_valid_0),
        .tx_ready(tx_ready_0), .tx(tx_0), .tx_oe(tx_oe_0), .busy(busy_0),
        .frame_done(frame_done_0)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_1 (
        .clk(clk), .rst(rst), .tx_data(drv_data), .tx_valid(tx_valid_1),
        .tx_ready(tx_ready_1), .tx(tx_1), .tx_oe(tx_oe_1), .busy(busy_1),
        .frame_done(frame_done_1)
    );

    always #5 clk = ~clk;

    // Line level for every cycle from the handshake edge, plus the first idle sample.
    function automatic logic [63:0] model_wave(input logic [7:0] d, input logic par);
        logic [10:0] bits;
        int          nb;
        logic [63:0] w;
        nb      = par ? 11 : 10;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (par) bits[9] = ^d;
        w = '0;
        for (int k = 0; k < nb * C; k++) w[k] = bits[k / C];
        w[nb * C] = 1'b1;
        return w;
    endfunction

    // Sends one word on the selected instance and records the outputs cycle by cycle.
    task automatic run_frame(input logic [7:0] d, input bit hold_valid, input bit disturb,
                             input int abort_at,
                             output logic [63:0] w_tx, output logic [63:0] w_busy,
                             output logic [63:0] w_rdy, output int done_at,
                             output int n_done, output int hs_wait);
        int n;
        n       = C * (sel ? 11 : 10);
        w_tx    = '0;
        w_busy  = '0;
        w_rdy   = '0;
        done_at = -1;
        n_done  = 0;
        hs_wait = -1;
        drv_data  = d;
        drv_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready_m === 1'b1) begin
                hs_wait = i;
                break;
            end
            @(negedge clk);
        end
        if (hs_wait < 0) begin
            drv_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) drv_valid = 1'b0;
        for (int k = 0; k <= n; k++) begin
            if (k == abort_at) begin
                drv_valid = 1'b0;
                rst       = 1'b1;
                return;
            end
            w_tx[k]   = tx_m;
            w_busy[k] = busy_m;
            w_rdy[k]  = tx_ready_m;
            if (done_m === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (k < n) begin
                if (disturb) begin
                    drv_valid = k[0];
                    drv_data  = 8'h3C;
                end
                @(negedge clk);
            end
        end
        if (!hold_valid) drv_valid = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        drv_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({tx_0, tx_oe_0, tx_ready_0, busy_0, frame_done_0} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_state_0: got %b expected 10000 (tx,oe,rdy,busy,done)",
                     {tx_0, tx_oe_0, tx_ready_0, busy_0, frame_done_0});
        end
        n_cmp++;
        if ({tx_1, tx_oe_1, tx_ready_1, busy_1, frame_done_1} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_state_1: got %b expected 10000 (tx,oe,rdy,busy,done)",
                     {tx_1, tx_oe_1, tx_ready_1, busy_1, frame_done_1});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({tx_oe_0, tx_ready_0, tx_oe_1, tx_ready_1} !== 4'b1111) begin
            n_bad++;
            $display("FAIL first_edge_arm: got %b expected 1111 (oe0,rdy0,oe1,rdy1)",
                     {tx_oe_0, tx_ready_0, tx_oe_1, tx_ready_1});
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({tx_0, tx_oe_0, tx_ready_0, busy_0, frame_done_0} !== 5'b11100) bad++;
            if ({tx_1, tx_oe_1, tx_ready_1, busy_1, frame_done_1} !== 5'b11100) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL idle_hold: got %0d bad idle samples expected 0", bad);
        end
    endtask

    task automatic test_single_frame;
        logic [63:0] w_tx, w_busy, w_rdy;
        int done_at, n_done, hs;
        sel = 1'b0;
        run_frame(8'hA5, 1'b0, 1'b0, -1, w_tx, w_busy, w_rdy, done_at, n_done, hs);
        n_cmp++;
        if (hs !== 0) begin
            n_bad++;
            $display("FAIL single_handshake: got wait %0d expected 0", hs);
        end
        n_cmp++;
        if (w_tx !== model_wave(8'hA5, 1'b0)) begin
            n_bad++;
            $display("FAIL single_wave: got %h expected %h", w_tx, model_wave(8'hA5, 1'b0));
        end
        n_cmp++;
        if (w_busy !== (64'(1) << 40) - 64'(1) || w_rdy !== 64'(1) << 40) begin
            n_bad++;
            $display("FAIL single_busy_ready: got busy %h ready %h", w_busy, w_rdy);
        end
        n_cmp++;
        if (done_at !== 40 || n_done !== 1) begin
            n_bad++;
            $display("FAIL single_done: got at %0d count %0d expected at 40 count 1",
                     done_at, n_done);
        end
    endtask

    task automatic test_parity;
        logic [63:0] w_tx, w_busy, w_rdy;
        int done_at, n_done, hs;
        logic [7:0] words [2];
        logic       pbit  [2];
        words[0] = 8'h07; pbit[0] = 1'b1;
        words[1] = 8'h03; pbit[1] = 1'b0;
        sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_frame(words[i], 1'b0, 1'b0, -1, w_tx, w_busy, w_rdy, done_at, n_done, hs);
            n_cmp++;
            if (w_tx[9*C] !== pbit[i]) begin
                n_bad++;
                $display("FAIL parity_bit_%h: got %b expected %b", words[i], w_tx[9*C], pbit[i]);
            end
            n_cmp++;
            if (hs < 0 || w_tx !== model_wave(words[i], 1'b1)) begin
                n_bad++;
                $display("FAIL parity_wave_%h: got %h expected %h", words[i], w_tx,
                         model_wave(words[i], 1'b1));
            end
            n_cmp++;
            if (done_at !== 44 || n_done !== 1) begin
                n_bad++;
                $display("FAIL parity_done_%h: got at %0d count %0d expected at 44 count 1",
                         words[i], done_at, n_done);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] t1, b1, r1, t2, b2, r2;
        int d1, c1, h1, d2, c2, h2, gap, bad;
        sel = 1'b0;
        run_frame(8'h00, 1'b1, 1'b0, -1, t1, b1, r1, d1, c1, h1);
        run_frame(8'hFF, 1'b0, 1'b0, -1, t2, b2, r2, d2, c2, h2);
        n_cmp++;
        if (t1 !== model_wave(8'h00, 1'b0) || t2 !== model_wave(8'hFF, 1'b0)) begin
            n_bad++;
            $display("FAIL b2b_waves: got %h / %h expected %h / %h", t1, t2,
                     model_wave(8'h00, 1'b0), model_wave(8'hFF, 1'b0));
        end
        gap = 0;
        for (int k = 10 * C; k >= 0; k--) begin
            if (t1[k] !== 1'b1) break;
            gap++;
        end
        n_cmp++;
        if (h2 !== 0 || gap !== C + 1) begin
            n_bad++;
            $display("FAIL b2b_gap: got wait %0d gap %0d expected wait 0 gap %0d", h2, gap, C + 1);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_0 !== 1'b0 || tx_0 !== 1'b1 || frame_done_0 !== 1'b0) bad++;
        end
        n_cmp++;
        if (c1 + c2 !== 2 || bad !== 0) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d done pulses %0d extra-activity cycles expected 2 and 0",
                     c1 + c2, bad);
        end
    endtask

    task automatic test_ignored_input;
        logic [63:0] w_tx, w_busy, w_rdy;
        int done_at, n_done, hs;
        logic [7:0] d;
        sel = 1'b0;
        d = 8'($urandom);
        if (d == 8'h3C) d = 8'hC3;
        run_frame(d, 1'b0, 1'b1, -1, w_tx, w_busy, w_rdy, done_at, n_done, hs);
        n_cmp++;
        if (hs < 0 || w_tx !== model_wave(d, 1'b0)) begin
            n_bad++;
            $display("FAIL ignored_wave: got %h expected %h", w_tx, model_wave(d, 1'b0));
        end
        n_cmp++;
        if (w_rdy !== 64'(1) << 40 || n_done !== 1) begin
            n_bad++;
            $display("FAIL ignored_ready: got ready %h done %0d expected %h done 1",
                     w_rdy, n_done, 64'(1) << 40);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] w_tx, w_busy, w_rdy, mask;
        int done_at, n_done, hs, bad;
        sel = 1'b0;
        // data bit 3 occupies cycles 16..19 after the handshake edge
        run_frame(8'h96, 1'b0, 1'b0, 17, w_tx, w_busy, w_rdy, done_at, n_done, hs);
        #1;
        mask = (64'(1) << 17) - 64'(1);
        n_cmp++;
        if (hs < 0 || (w_tx & mask) !== (model_wave(8'h96, 1'b0) & mask)) begin
            n_bad++;
            $display("FAIL abort_prefix: got %h expected %h", w_tx & mask,
                     model_wave(8'h96, 1'b0) & mask);
        end
        n_cmp++;
        if ({tx_0, busy_0, frame_done_0, tx_ready_0, tx_oe_0} !== 5'b10000) begin
            n_bad++;
            $display("FAIL abort_immediate: got %b expected 10000 (tx,busy,done,rdy,oe)",
                     {tx_0, busy_0, frame_done_0, tx_ready_0, tx_oe_0});
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_0 !== 1'b1 || frame_done_0 !== 1'b0) bad++;
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx_0 !== 1'b1 || frame_done_0 !== 1'b0 || busy_0 !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad);
        end
        run_frame(8'h5A, 1'b0, 1'b0, -1, w_tx, w_busy, w_rdy, done_at, n_done, hs);
        n_cmp++;
        if (hs < 0 || w_tx !== model_wave(8'h5A, 1'b0) || done_at !== 40 || n_done !== 1) begin
            n_bad++;
            $display("FAIL abort_resend: got %h done %0d/%0d expected %h done 40/1",
                     w_tx, done_at, n_done, model_wave(8'h5A, 1'b0));
        end
    endtask

    task automatic test_random;
        logic [63:0] w_tx, w_busy, w_rdy;
        int done_at, n_done, hs, nb;
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            sel = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            nb = sel ? 11 : 10;
            run_frame(d, 1'b0, 1'b0, -1, w_tx, w_busy, w_rdy, done_at, n_done, hs);
            n_cmp++;
            if (hs < 0 || w_tx !== model_wave(d, sel)) begin
                n_bad++;
                $display("FAIL random_wave_%0d: data %h par %b got %h expected %h",
                         i, d, sel, w_tx, model_wave(d, sel));
            end
            n_cmp++;
            if (done_at !== nb * C || n_done !== 1) begin
                n_bad++;
                $display("FAIL random_done_%0d: got at %0d count %0d expected at %0d count 1",
                         i, done_at, n_done, nb * C);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        drv_data  = 8'h00;
        drv_valid = 1'b0;
        sel       = 1'b0;
        n_cmp     = 0;
        n_bad     = 0;
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_parity;
        test_back_to_back;
        test_ignored_input;
        test_reset_mid_frame;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Byte-serial transmitter: accepts 8-bit words over a valid/ready handshake and shifts them out on one pin as asynchronous serial frames (start, 8 data LSB-first, optional even parity, 1 stop).
- It is the sending end of the pin-level serial link and sits inside the user top module.
- `tx` drives one `uo_out` or `uio_out` bit; `tx_oe` drives the matching `uio_oe` bit when a bidirectional pin is used.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  word to send; sampled only on handshake.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block can accept a word; handshake = tx_valid & tx_ready at a rising edge.
- tx  output  1  serial line; idle high.
- tx_oe  output  1  output enable for the pin.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset values (asynchronous, immediate):
  - tx=1, tx_ready=0, busy=0, frame_done=0, tx_oe=0.
  - State=IDLE, bit counter=0, baud counter=0, shift register=0.
- After reset deasserts:
  - First rising edge sets tx_oe=1; it stays 1 until the next reset.
  - tx_ready goes 1 on that same edge.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1, busy=0.
  - On handshake, latch tx_data into the shift register, compute parity = XOR of the 8 data bits, go to START.
  - From that edge: tx=0, tx_ready=0, busy=1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=bit0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After bit7 completes: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = parity bit, giving even parity over data+parity; held CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final edge: return to IDLE, tx_ready=1, busy=0, frame_done=1 for exactly one cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width = clog2(CLKS_PER_BIT).
  - Reloaded to 0 on handshake.
- Frame length:
  - Start edge to IDLE is exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with PARITY_EN=1.
- Back-to-back: with tx_valid held high, the next handshake occurs in the first IDLE cycle. The line therefore shows stop-high for CLKS_PER_BIT+1 cycles between frames.
- Ignored inputs: tx_valid and tx_data changes outside IDLE have no effect; a word is neither lost nor duplicated.
- tx_valid low in IDLE: remain IDLE with tx=1 indefinitely.
- Reset mid-frame: tx returns to 1 immediately, the frame is truncated, and no frame_done is generated. The block re-arms per the reset rules.

Test Plan:
- Reset and idle: hold rst 5 cycles, release, tx_valid=0 for 50 cycles -> tx=1 throughout; tx_oe 0 during reset, then 1 from the first edge after release; tx_ready=1; busy=0.
- Single frame (CLKS_PER_BIT=4, PARITY_EN=0), send 0xA5 -> handshake in one cycle, then:
  - tx = 0 for 4 cycles;
  - data bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - stop 1 for 4 cycles;
  - frame_done pulses once, 40 cycles after the handshake edge.
- Parity (CLKS_PER_BIT=4, PARITY_EN=1):
  - Send 0x07 -> parity bit = 1; send 0x03 -> parity bit = 0.
  - Each frame is 44 cycles; frame_done occurs once per frame.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> two frames; stop-high gap of exactly 5 cycles between them; second frame bits all 1; exactly two handshakes and two frame_done pulses.
- Ignored input: during a frame, toggle tx_valid and change tx_data to 0x3C -> the transmitted byte is unchanged and tx_ready stays 0 until the stop bit completes.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 in the same cycle, busy=0, no frame_done. After release, a new send of 0x5A produces a correct full frame.
